// File: rtl/data_sram_responder.sv
// data_sram_responder: slave end of the sram-like req/addr_ok/data_ok data
// port. A word-organised RAM answers each accepted request after LATENCY
// wait cycles. Out-of-range, misaligned and size==3 accesses get resp_err.
//
// Handshake rule: a request transfers on a rising edge where req & addr_ok
// are both high. addr_ok depends only on state, never on req. data_ok is a
// one-cycle pulse, and rdata/resp_err are meaningful only while it is high.
module data_sram_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic [1:0]  state_dbg
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem_q [DEPTH];

  logic          accept;
  logic          resp;
  logic          err;
  logic          do_write;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [3:0]    be;

  assign state_dbg = state_q;
  assign addr_ok   = (state_q == S_IDLE) || (state_q == S_RESP);
  assign accept    = req && addr_ok;

  // Decode the latched request: word index, error flags and byte enables.
  always_comb begin
    off = addr_q - BASE_ADDR;
    idx = off[AW+1:2];
    err = (off >= SPAN) || (size_q == 2'd3) ||
          ((size_q == 2'd1) && addr_q[0]) ||
          ((size_q == 2'd2) && (addr_q[1:0] != 2'b00));
    be  = 4'b0000;
    case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Response outputs exist only in the RESP cycle; a reset in that cycle
  // suppresses both the pulse and the write commit.
  always_comb begin
    resp     = (state_q == S_RESP) && !rst;
    do_write = resp && wr_q && !err;
    data_ok  = resp;
    resp_err = resp && err;
    rdata    = (resp && !wr_q && !err) ? mem_q[idx] : 32'h0;
  end

  // Next-state: capture the bus on a handshake, count wait cycles, respond.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
          cnt_d   = CNT_INIT;
          wr_d    = wr;
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // RAM byte-lane write on the RESP cycle; contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (do_write && be[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

endmodule
